// File: rtl/rs232_pkg.sv
// Register map and shared types for the RS-232 UART front end, used by both
// the program loader and the result transmitter.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         TX_OK_BIT   = 6;
  localparam int         RX_OK_BIT   = 7;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DATA  = 2'd1,
    S_FLUSH = 2'd2,
    S_START = 2'd3
  } loader_state_t;

  typedef enum logic {
    P_STATUS = 1'b0,
    P_RX     = 1'b1
  } poll_state_t;

  function automatic logic [31:0] clamp_words(input logic [31:0] n, input logic [31:0] lim);
    return (n < lim) ? n : lim;
  endfunction

endpackage

// File: rtl/rs232_avm_rx_byte.sv
// Avalon-MM poller: reads UART STATUS until RX_OK, then reads RX once and
// presents the received byte for exactly the completion cycle.
module rs232_avm_rx_byte
  import rs232_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        poll_state
);

  poll_state_t state;
  poll_state_t state_next;
  logic        done;
  logic        unused_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= P_STATUS;
    else        state <= state_next;
  end

  // Avalon handshake: a read completes when avm_read && !avm_waitrequest;
  // the address is a pure function of state, so it cannot move while stalled.
  always_comb begin
    state_next = state;
    done       = !avm_waitrequest;
    case (state)
      P_STATUS: if (done && avm_readdata[RX_OK_BIT]) state_next = P_RX;
      P_RX:     if (done) state_next = P_STATUS;
      default:  state_next = P_STATUS;
    endcase
  end

  assign avm_read    = 1'b1;
  assign avm_address = (state == P_RX) ? RX_BASE : STATUS_BASE;
  assign byte_valid  = rst_n && (state == P_RX) && !avm_waitrequest;
  assign byte_data   = avm_readdata[7:0];
  assign poll_state  = (state == P_RX);
  assign unused_bits = ^avm_readdata[31:8];

endmodule

// File: rtl/rs232_loader.sv
// Frames UART bytes (MSB first) into a length-prefixed program image, writes it
// to instruction memory and pulses o_start when the image is complete.
module rs232_loader
  import rs232_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              avm_clk,
  input  logic              avm_rst_n,
  output logic [4:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_start,
  output logic              o_loading,
  output logic              o_abort,
  output logic [2:0]        dbg_state
);

  localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          poll_state;

  loader_state_t state;
  loader_state_t state_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   word;
  logic [31:0]   n_words;
  logic [31:0]   load_cnt;
  logic [31:0]   word_idx;
  logic [31:0]   tmo_cnt;
  logic          loading;
  logic          mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  logic [31:0]   full_word;
  logic          word_done;
  logic          last_word;
  logic          store_word;
  logic          tmo_hit;

  rs232_avm_rx_byte u_rx_byte (
    .clk             (avm_clk),
    .rst_n           (avm_rst_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .poll_state      (poll_state)
  );

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) state <= S_HDR;
    else            state <= state_next;
  end

  always_comb begin
    full_word  = {word[23:0], byte_data};
    word_done  = byte_valid && (byte_cnt == 2'd3);
    last_word  = word_done && (word_idx == n_words - 32'd1);
    store_word = word_done && (word_idx < load_cnt);
    // A byte landing in the expiry cycle keeps the frame alive.
    tmo_hit    = 1'b0;
    if (TMO_EN && loading && !byte_valid && (tmo_cnt == TMO_LAST) &&
        ((state == S_HDR) || (state == S_DATA)))
      tmo_hit = 1'b1;
    state_next = state;
    case (state)
      S_HDR: begin
        if (!tmo_hit && word_done) state_next = (full_word == 32'd0) ? S_START : S_DATA;
      end
      S_DATA: begin
        if (tmo_hit)        state_next = S_HDR;
        else if (last_word) state_next = S_FLUSH;
      end
      S_FLUSH: state_next = S_START;
      S_START: state_next = S_HDR;
      default: state_next = S_HDR;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      byte_cnt  <= 2'd0;
      word      <= 32'd0;
      n_words   <= 32'd0;
      load_cnt  <= 32'd0;
      word_idx  <= 32'd0;
      tmo_cnt   <= 32'd0;
      loading   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (tmo_hit) begin
        byte_cnt <= 2'd0;
        word_idx <= 32'd0;
        tmo_cnt  <= 32'd0;
        loading  <= 1'b0;
      end else begin
        if (byte_valid) begin
          word     <= full_word;
          // A byte in the start cycle is already the first header byte of the next image.
          byte_cnt <= (state == S_START) ? 2'd1 : byte_cnt + 2'd1;
          tmo_cnt  <= 32'd0;
          loading  <= 1'b1;
        end else if (TMO_EN && loading) begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
        if ((state == S_HDR) && word_done) begin
          n_words  <= full_word;
          load_cnt <= clamp_words(full_word, MAX_W);
          word_idx <= 32'd0;
        end
        if ((state == S_DATA) && word_done) begin
          word_idx <= word_idx + 32'd1;
          if (store_word) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_idx[MEM_AW-1:0];
            mem_wdata <= full_word;
          end
        end
        if (state == S_START) word_idx <= 32'd0;
        if (state_next == S_START) loading <= 1'b0;
      end
    end
  end

  assign o_mem_we    = mem_we;
  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_start     = (state == S_START);
  assign o_loading   = loading;
  assign o_abort     = avm_rst_n && tmo_hit;
  assign dbg_state   = {poll_state, state};

endmodule

// File: tb/tb_rs232_loader.sv
// Bench for rs232_loader: a UART register model feeds byte streams, a byte-level
// frame model predicts writes, start, loading and abort on every cycle.
module tb_rs232_loader;

  localparam int MEM_AW    = 4;
  localparam int MAX_WORDS = 6;
  localparam int TMO       = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [4:0]        avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata = 32'd0;
  logic              avm_waitrequest = 1'b1;
  logic              o_mem_we;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              o_start;
  logic              o_loading;
  logic              o_abort;
  logic [2:0]        dbg_state;

  rs232_loader #(.MEM_AW(MEM_AW), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TMO)) dut (
    .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_start(o_start), .o_loading(o_loading), .o_abort(o_abort), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // ---------------- UART host side ----------------
  logic [7:0] host_q[$];
  int stall_mode = 0;
  int stall_left = 0;
  int rxok_block = 0;

  // ---------------- reference model ----------------
  bit          m_active = 0;
  int          m_nb = 0;
  int          m_phase = 0;
  logic [31:0] m_word = 0;
  logic [31:0] m_n = 0;
  logic [31:0] m_idx = 0;
  int          m_deadline = 0;
  int          m_last_byte = 0;
  int          last_event = 0;
  bit          exp_we_a[int];
  logic [MEM_AW-1:0] exp_addr_a[int];
  logic [31:0] exp_data_a[int];
  bit          exp_start_a[int];
  bit          exp_load_a[int];
  bit          cur_load = 0;

  // ---------------- observation ----------------
  logic [31:0] mem [0:15];
  int          n_writes = 0;
  int          last_we = -1;
  logic [MEM_AW-1:0] last_we_addr = '0;
  int          last_start = -1;
  int          last_abort = -1;
  bit          stalled = 0;
  logic [4:0]  stall_addr = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void note_event(input int c);
    if (c > last_event) last_event = c;
  endfunction

  function automatic void finish_frame(input int s);
    exp_start_a[s] = 1'b1;
    exp_load_a[s]  = 1'b0;
    m_active = 1'b0;
    note_event(s);
  endfunction

  // One received byte in cycle c, interpreted as a length-prefixed word stream.
  function automatic void model_byte(input logic [7:0] b, input int c);
    if (!m_active) begin
      m_active = 1'b1;
      m_phase  = 0;
      m_nb     = 0;
      exp_load_a[c+1] = 1'b1;
    end
    m_last_byte = c;
    m_deadline  = c + TMO;
    m_word = {m_word[23:0], b};
    m_nb++;
    note_event(c + 1);
    if (m_nb == 4) begin
      m_nb = 0;
      if (m_phase == 0) begin
        m_n = m_word;
        m_idx = 0;
        if (m_n == 0) finish_frame(c + 1);
        else m_phase = 1;
      end else begin
        if (m_idx < MAX_WORDS) begin
          exp_we_a[c+1]   = 1'b1;
          exp_addr_a[c+1] = m_idx[MEM_AW-1:0];
          exp_data_a[c+1] = m_word;
        end
        m_idx++;
        if (m_idx == m_n) finish_frame(c + 2);
      end
    end
  endfunction

  // ---------------- UART consumption / model update ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      host_q.delete();
      exp_we_a.delete(); exp_addr_a.delete(); exp_data_a.delete();
      exp_start_a.delete(); exp_load_a.delete();
      m_active = 0; m_nb = 0; m_phase = 0; cur_load = 0;
      stalled = 0; stall_left = 0; rxok_block = 0;
    end else if (avm_read && !avm_waitrequest) begin
      stalled = 0;
      if (avm_address == 5'd0) begin
        if (host_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_read_without_data cyc=%0d actual=empty required=byte", cyc);
        end else begin
          model_byte(host_q.pop_front(), cyc);
        end
      end else if (rxok_block > 0) begin
        rxok_block--;
      end
    end else begin
      stalled    = avm_read;
      stall_addr = avm_address;
    end
    cyc++;
  end

  // ---------------- Avalon slave driver + per-cycle compare ----------------
  always @(negedge clk) begin
    logic        wr;
    logic [31:0] rdata;
    logic        byte_now;
    bit          exp_we;
    bit          exp_abort;
    wr = 1'b0;
    case (stall_mode)
      1: wr = ($urandom_range(0, 3) == 0);
      2: begin
        if (stall_left > 0) begin wr = 1'b1; stall_left--; end
        else begin wr = 1'b0; stall_left = 5; end
      end
      default: wr = 1'b0;
    endcase
    rdata = $urandom;
    if (avm_address == 5'd8)
      rdata[7] = (host_q.size() > 0) && (rxok_block == 0) &&
                 ((stall_mode != 1) || ($urandom_range(0, 1) == 1));
    else if (host_q.size() > 0)
      rdata[7:0] = host_q[0];
    avm_waitrequest = wr;
    avm_readdata    = rdata;
    #1;
    if (rst_n) begin
      byte_now = (avm_address == 5'd0) && !avm_waitrequest;
      check("avm_read", {31'd0, avm_read}, 32'd1);
      if (stalled) check("addr_stable", {27'd0, avm_address}, {27'd0, stall_addr});
      exp_we = exp_we_a.exists(cyc);
      check("mem_we", {31'd0, o_mem_we}, {31'd0, exp_we});
      if (exp_we) begin
        check("mem_addr", {28'd0, o_mem_addr}, {28'd0, exp_addr_a[cyc]});
        check("mem_wdata", o_mem_wdata, exp_data_a[cyc]);
      end
      if (o_mem_we) begin
        mem[o_mem_addr] = o_mem_wdata;
        n_writes++;
        last_we = cyc;
        last_we_addr = o_mem_addr;
      end
      check("start", {31'd0, o_start}, {31'd0, exp_start_a.exists(cyc)});
      if (o_start) last_start = cyc;
      if (exp_load_a.exists(cyc)) cur_load = exp_load_a[cyc];
      check("loading", {31'd0, o_loading}, {31'd0, cur_load});
      exp_abort = m_active && (cyc == m_deadline) && !byte_now;
      check("abort", {31'd0, o_abort}, {31'd0, exp_abort});
      if (exp_abort) begin
        m_active = 0;
        m_nb = 0;
        exp_load_a[cyc+1] = 1'b0;
      end
      if (o_abort) last_abort = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [31:0] w);
    host_q.push_back(w[31:24]);
    host_q.push_back(w[23:16]);
    host_q.push_back(w[15:8]);
    host_q.push_back(w[7:0]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((host_q.size() != 0 || m_active || cyc <= last_event + 2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle within %0d", cyc, budget);
    end
  endtask

  task automatic wait_sent(input int budget);
    int n = 0;
    while (host_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_sent cyc=%0d actual=%0d bytes left required=0", cyc, host_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, {27'd0, avm_address}, 32'd8);
    check({tag, "_read"}, {31'd0, avm_read}, 32'd1);
    check({tag, "_we"}, {31'd0, o_mem_we}, 32'd0);
    check({tag, "_maddr"}, {28'd0, o_mem_addr}, 32'd0);
    check({tag, "_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_start"}, {31'd0, o_start}, 32'd0);
    check({tag, "_loading"}, {31'd0, o_loading}, 32'd0);
    check({tag, "_abort"}, {31'd0, o_abort}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_reset_values("reset");

    // Two-word image
    push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567);
    wait_idle(2000);
    check("t1_mem0", mem[0], 32'hDEADBEEF);
    check("t1_mem1", mem[1], 32'h01234567);
    check("t1_start_lat", last_start - last_we, 32'd1);

    // Empty image
    w0 = n_writes;
    push_word(32'd0);
    wait_idle(2000);
    check("t2_no_writes", n_writes - w0, 32'd0);
    check("t2_start_lat", last_start - m_last_byte, 32'd1);

    // Oversized image: only MAX_WORDS stored, rest consumed
    w0 = n_writes;
    push_word(32'd8);
    for (int i = 0; i < 8; i++) push_word($urandom);
    wait_idle(4000);
    check("t3_writes", n_writes - w0, 32'd6);
    check("t3_last_addr", {28'd0, last_we_addr}, 32'd5);
    check("t3_start_lat", last_start - m_last_byte, 32'd2);

    // Stalled bus and slow RX_OK, same image as before
    mem[0] = 32'd0; mem[1] = 32'd0;
    stall_mode = 2;
    rxok_block = 10;
    push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567);
    wait_idle(6000);
    check("t4_mem0", mem[0], 32'hDEADBEEF);
    check("t4_mem1", mem[1], 32'h01234567);

    // Mid-frame timeout then a normal frame
    stall_mode = 0;
    push_word(32'd1); host_q.push_back(8'hAA);
    wait_idle(1000);
    check("t5_abort_lat", last_abort - m_last_byte, 32'd100);
    push_word(32'd1); push_word(32'h12345678);
    wait_idle(2000);
    check("t5_mem0", mem[0], 32'h12345678);

    // Reset after two payload bytes
    push_word(32'd2); host_q.push_back(8'h11); host_q.push_back(8'h22);
    wait_sent(500);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_reset_values("t6");
    push_word(32'd1); push_word(32'hCAFEF00D);
    wait_idle(2000);
    check("t6_mem0", mem[0], 32'hCAFEF00D);
    check("t6_addr", {28'd0, last_we_addr}, 32'd0);

    // Randomized images, sometimes two back to back
    for (int it = 0; it < 12; it++) begin
      int nf;
      stall_mode = $urandom_range(0, 2);
      nf = $urandom_range(1, 2);
      for (int f = 0; f < nf; f++) begin
        int n;
        n = $urandom_range(0, 9);
        push_word(n);
        for (int k = 0; k < n; k++) push_word($urandom);
      end
      wait_idle(20000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
